// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. Each digit owns one scan slot of REFRESH_DIV cycles. The first
// BLANK_CYCLES of a slot keep every anode off to suppress ghosting, and the
// rest of the slot shows the digit. Display data is double-buffered: a load
// goes into staging and is applied only at the frame boundary, so a frame
// never shows a partial update.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   value      in   hex nibbles, nibble i drives digit i (0 = rightmost)
//   digit_en   in   per-digit enable, 0 = digit dark
//   lz_blank   in   leading-zero suppression, sampled live
//   load       in   1-cycle request to capture value/digit_en into staging
//   load_ack   out  1-cycle pulse when staging reaches the display register
//   code       out  decoder input, 5'h10 = all segments off
//   anodes     out  active-low digit selects, at most one low
//   frame_done out  1-cycle pulse after the last slot of every frame
//
// FSM states (one pass per slot)
//   state    | meaning
//   ST_BLANK | cnt < BLANK_CYCLES, all anodes off
//   ST_SHOW  | remainder of slot, digit idx shown unless dark
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic                    load_ack,
  output logic [4:0]              code,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [4:0] CODE_BLANK = 5'h10;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;
  // With no blank interval the slot starts directly in SHOW.
  localparam state_t ST_INIT = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] idx;
  logic             cnt_wrap, frame_end, blank_next;
  state_t           state, state_next;

  logic [4*NUM_DIGITS-1:0] staging_value, disp_value;
  logic [NUM_DIGITS-1:0]   staging_en, disp_en;
  logic                    pending;

  logic [NUM_DIGITS-1:0] zero_from;
  logic                  zero_run;
  logic [3:0]            nibble;
  logic                  digit_dark;
  logic [NUM_DIGITS-1:0] anodes_next;
  logic [4:0]            code_next;

  // Slot / digit position
  assign cnt_wrap  = (cnt == CNT_LAST);
  assign frame_end = cnt_wrap && (idx == IDX_LAST);
  assign cnt_next  = cnt_wrap ? '0 : cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_next;
      if (cnt_wrap) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  // The FSM state tracks the phase of the current cnt, so its next value is
  // derived from cnt_next. A zero-length blank interval needs no compare.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign blank_next = 1'b0;
    end else begin : g_blank
      assign blank_next = (cnt_next < CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_INIT;
    else       state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = blank_next ? ST_BLANK : ST_SHOW;
  end

  // Leading-zero run: zero_from[i] is set when nibbles NUM_DIGITS-1..i are 0.
  always_comb begin
    zero_from = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp_value[4*i +: 4] == 4'h0);
      zero_from[i] = zero_run;
    end
  end

  assign nibble     = 4'(disp_value >> {idx, 2'b00});
  assign digit_dark = !disp_en[idx] ||
                      (lz_blank && (idx != '0) && zero_from[idx]);

  // FSM: outputs (registered below, so they trail (idx, cnt) by one cycle)
  always_comb begin
    anodes_next = '1;
    code_next   = CODE_BLANK;
    unique case (state)
      ST_BLANK: begin
        anodes_next = '1;
        code_next   = CODE_BLANK;
      end
      ST_SHOW: begin
        if (!digit_dark) begin
          anodes_next = ~(NUM_DIGITS'(1) << idx);
          code_next   = {1'b0, nibble};
        end
      end
      default: begin
        anodes_next = '1;
        code_next   = CODE_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anodes <= '1;
      code   <= CODE_BLANK;
    end else begin
      anodes <= anodes_next;
      code   <= code_next;
    end
  end

  // Double buffer. A load in the boundary cycle lands in staging after the
  // transfer has used the old staging, and keeps pending set for next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging_value <= '0;
      staging_en    <= '0;
      pending       <= 1'b0;
      disp_value    <= '0;
      disp_en       <= '1;
      load_ack      <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      load_ack   <= frame_end && pending;
      frame_done <= frame_end;
      if (frame_end && pending) begin
        disp_value <= staging_value;
        disp_en    <= staging_en;
        pending    <= 1'b0;
      end
      if (load) begin
        staging_value <= value;
        staging_en    <= digit_en;
        pending       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. Outputs are sampled on the falling edge. A frame capture
// starts in the frame_done cycle and records the 32 following samples; sample
// p shows slot p/8, slot cycle p%8, and sample 31 is the next frame_done cycle.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  digit_en = '0;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic        load_ack;
  logic [4:0]  code;
  logic [3:0]  anodes;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [3:0] obs_an [32];
  logic [4:0] obs_code [32];
  int         fd_mid, ack_mid;
  logic       fd_end, ack_end;

  int          sched_at [$];
  logic [15:0] sched_val [$];
  logic [3:0]  sched_en [$];

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .digit_en(digit_en),
    .lz_blank(lz_blank),
    .load(load),
    .load_ack(load_ack),
    .code(code),
    .anodes(anodes),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Expected {anodes, code} for frame sample p.
  function automatic logic [8:0] model_out(logic [15:0] v, logic [3:0] en,
                                           logic lz, int p);
    int s = p / 8;
    int c = p % 8;
    logic dark;
    logic zero;
    logic [3:0] an;
    if (c < 2) return {4'hF, 5'h10};
    dark = !en[s];
    if (lz && s > 0) begin
      zero = 1'b1;
      for (int k = s; k < 4; k++) if (v[k*4 +: 4] != 4'h0) zero = 1'b0;
      if (zero) dark = 1'b1;
    end
    if (dark) return {4'hF, 5'h10};
    an = 4'hF;
    an[s] = 1'b0;
    return {an, 1'b0, v[s*4 +: 4]};
  endfunction

  // Records one frame of outputs, driving any scheduled loads on the way.
  task automatic capture_frame();
    fd_mid = 0;
    ack_mid = 0;
    for (int p = 0; p < 32; p++) begin
      @(negedge clk);
      obs_an[p] = anodes;
      obs_code[p] = code;
      if (p < 31) begin
        fd_mid += int'(frame_done);
        ack_mid += int'(load_ack);
      end else begin
        fd_end = frame_done;
        ack_end = load_ack;
      end
      if (sched_at.size() > 0 && sched_at[0] == p) begin
        void'(sched_at.pop_front());
        value = sched_val.pop_front();
        digit_en = sched_en.pop_front();
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (anodes !== 4'hF || code !== 5'h10) begin
      errors++;
      $display("FAIL reset_outputs got anodes=%b code=%h want anodes=1111 code=10", anodes, code);
    end
    checks++;
    if (load_ack !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses got load_ack=%b frame_done=%b want 0 0", load_ack, frame_done);
    end
    reset = 1'b0;
  endtask

  // First frame after release: display=0, all enabled, so every slot shows 00.
  task automatic test_scan_after_reset();
    logic [8:0] exp;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      exp = model_out(16'h0000, 4'hF, 1'b0, j - 1);
      checks++;
      if ({anodes, code} !== exp) begin
        errors++;
        $display("FAIL scan_after_reset j=%0d got anodes=%b code=%h want anodes=%b code=%h",
                 j, anodes, code, exp[8:5], exp[4:0]);
      end
      checks++;
      if (frame_done !== (j == 32) || load_ack !== 1'b0) begin
        errors++;
        $display("FAIL frame_period j=%0d got frame_done=%b load_ack=%b want frame_done=%b load_ack=0",
                 j, frame_done, load_ack, (j == 32));
      end
    end
  endtask

  task automatic test_load();
    logic [8:0] exp;
    sched_at.push_back(4); sched_val.push_back(16'h12AF); sched_en.push_back(4'hF);
    capture_frame();
    for (int p = 0; p < 32; p++) begin
      exp = model_out(16'h0000, 4'hF, 1'b0, p);
      checks++;
      if ({obs_an[p], obs_code[p]} !== exp) begin
        errors++;
        $display("FAIL load_old_frame p=%0d got anodes=%b code=%h want anodes=%b code=%h",
                 p, obs_an[p], obs_code[p], exp[8:5], exp[4:0]);
      end
    end
    checks++;
    if (ack_mid != 0 || ack_end !== 1'b1 || fd_end !== 1'b1) begin
      errors++;
      $display("FAIL load_ack_once got mid_acks=%0d end_ack=%b end_fd=%b want 0 1 1", ack_mid, ack_end, fd_end);
    end
    capture_frame();
    for (int p = 0; p < 32; p++) begin
      exp = model_out(16'h12AF, 4'hF, 1'b0, p);
      checks++;
      if ({obs_an[p], obs_code[p]} !== exp) begin
        errors++;
        $display("FAIL load_new_frame p=%0d got anodes=%b code=%h want anodes=%b code=%h",
                 p, obs_an[p], obs_code[p], exp[8:5], exp[4:0]);
      end
    end
    checks++;
    if (ack_mid != 0 || ack_end !== 1'b0) begin
      errors++;
      $display("FAIL load_no_extra_ack got mid_acks=%0d end_ack=%b want 0 0", ack_mid, ack_end);
    end
  endtask

  task automatic test_lz_blank();
    logic [8:0] exp;
    lz_blank = 1'b1;
    sched_at.push_back(5); sched_val.push_back(16'h0050); sched_en.push_back(4'hF);
    capture_frame();
    checks++;
    if (ack_end !== 1'b1) begin
      errors++;
      $display("FAIL lz_load_ack got %b want 1", ack_end);
    end
    sched_at.push_back(5); sched_val.push_back(16'h0000); sched_en.push_back(4'hF);
    capture_frame();
    for (int p = 0; p < 32; p++) begin
      exp = model_out(16'h0050, 4'hF, 1'b1, p);
      checks++;
      if ({obs_an[p], obs_code[p]} !== exp) begin
        errors++;
        $display("FAIL lz_0050 p=%0d got anodes=%b code=%h want anodes=%b code=%h",
                 p, obs_an[p], obs_code[p], exp[8:5], exp[4:0]);
      end
    end
    capture_frame();
    for (int p = 0; p < 32; p++) begin
      exp = model_out(16'h0000, 4'hF, 1'b1, p);
      checks++;
      if ({obs_an[p], obs_code[p]} !== exp) begin
        errors++;
        $display("FAIL lz_zero p=%0d got anodes=%b code=%h want anodes=%b code=%h",
                 p, obs_an[p], obs_code[p], exp[8:5], exp[4:0]);
      end
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_digit_en();
    logic [8:0] exp;
    sched_at.push_back(9); sched_val.push_back(16'h4321); sched_en.push_back(4'b0101);
    capture_frame();
    capture_frame();
    for (int p = 0; p < 32; p++) begin
      exp = model_out(16'h4321, 4'b0101, 1'b0, p);
      checks++;
      if ({obs_an[p], obs_code[p]} !== exp) begin
        errors++;
        $display("FAIL digit_en p=%0d got anodes=%b code=%h want anodes=%b code=%h",
                 p, obs_an[p], obs_code[p], exp[8:5], exp[4:0]);
      end
    end
    checks++;
    if (fd_mid != 0 || fd_end !== 1'b1) begin
      errors++;
      $display("FAIL digit_en_slot_len got mid_fd=%0d end_fd=%b want 0 1", fd_mid, fd_end);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    sched_at.push_back(3);  sched_val.push_back(16'h1111); sched_en.push_back(4'hF);
    sched_at.push_back(10); sched_val.push_back(16'h2222); sched_en.push_back(4'hF);
    sched_at.push_back(30); sched_val.push_back(16'h3333); sched_en.push_back(4'hF);
    capture_frame();
    checks++;
    if (ack_mid != 0 || ack_end !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_ack got mid_acks=%0d end_ack=%b want 0 1", ack_mid, ack_end);
    end
    capture_frame();
    for (int p = 0; p < 32; p++) begin
      exp = model_out(16'h2222, 4'hF, 1'b0, p);
      checks++;
      if ({obs_an[p], obs_code[p]} !== exp) begin
        errors++;
        $display("FAIL b2b_2222 p=%0d got anodes=%b code=%h want anodes=%b code=%h",
                 p, obs_an[p], obs_code[p], exp[8:5], exp[4:0]);
      end
    end
    checks++;
    if (ack_mid != 0 || ack_end !== 1'b1) begin
      errors++;
      $display("FAIL b2b_boundary_ack got mid_acks=%0d end_ack=%b want 0 1", ack_mid, ack_end);
    end
    capture_frame();
    for (int p = 0; p < 32; p++) begin
      exp = model_out(16'h3333, 4'hF, 1'b0, p);
      checks++;
      if ({obs_an[p], obs_code[p]} !== exp) begin
        errors++;
        $display("FAIL b2b_3333 p=%0d got anodes=%b code=%h want anodes=%b code=%h",
                 p, obs_an[p], obs_code[p], exp[8:5], exp[4:0]);
      end
    end
    checks++;
    if (ack_mid != 0 || ack_end !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_third_ack got mid_acks=%0d end_ack=%b want 0 0", ack_mid, ack_end);
    end
  endtask

  // Starts in a frame_done cycle with 16'h3333 displayed.
  task automatic test_reset_mid_slot();
    int acks = 0;
    for (int p = 0; p <= 20; p++) begin
      @(negedge clk);
      if (p == 0) begin
        value = 16'h5555;
        digit_en = 4'hF;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    checks++;
    if (anodes !== 4'b1011 || code !== 5'h03) begin
      errors++;
      $display("FAIL pre_reset_show got anodes=%b code=%h want anodes=1011 code=03", anodes, code);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (anodes !== 4'hF || code !== 5'h10) begin
      errors++;
      $display("FAIL async_reset got anodes=%b code=%h want anodes=1111 code=10", anodes, code);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      acks += int'(load_ack);
      if (j == 3) begin
        checks++;
        if (anodes !== 4'b1110 || code !== 5'h00) begin
          errors++;
          $display("FAIL post_reset_display got anodes=%b code=%h want anodes=1110 code=00", anodes, code);
        end
      end
      if (j == 31 || j == 32) begin
        checks++;
        if (frame_done !== (j == 32)) begin
          errors++;
          $display("FAIL post_reset_frame j=%0d got frame_done=%b want %b", j, frame_done, (j == 32));
        end
      end
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL pending_discarded got %0d acks want 0", acks);
    end
  endtask

  initial begin
    test_reset();
    test_scan_after_reset();
    test_load();
    test_lz_blank();
    test_digit_en();
    test_back_to_back();
    test_reset_mid_slot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
